// File: rtl/cpu_pkg.sv
// Shared definitions for the MIPS core pipeline registers.
//   HANDLER_PC_DEFAULT : exception vector loaded on a flush request
//   EXC_*              : 5-bit CP0 Cause.ExcCode values (EXC_NONE = no exception)
//   tnew_t             : default-width T_new field
//   PC8_OFFSET         : distance from an instruction to its return address (PC+8)
package cpu_pkg;

    localparam logic [31:0] HANDLER_PC_DEFAULT = 32'h0000_4180;
    localparam logic [31:0] PC8_OFFSET         = 32'd8;

    localparam int TNEW_W_DEFAULT = 2;
    typedef logic [TNEW_W_DEFAULT-1:0] tnew_t;

    // ExcCode values. EXC_NONE shares the encoding of Int because an
    // interrupt is never carried down the pipe as a stage exception code.
    localparam logic [4:0] EXC_NONE = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_SYS  = 5'd8;
    localparam logic [4:0] EXC_BP   = 5'd9;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter.
//   clk   : clock, rising edge
//   reset : asynchronous active-high clear
//   inc   : count up by one this edge (ignored once all-ones)
//   count : current value
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (inc && (count != {CNT_W{1'b1}})) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic inter-stage pipeline register (D/E, E/M, M/W).
// Inputs d_* are captured into q_* with one cycle of latency. Per-edge
// priority: req (flush to handler) > clr (bubble) > hold (freeze) > load.
//   clk, reset        : clock; asynchronous active-high reset
//   req               : exception/interrupt flush to HANDLER_PC
//   clr               : insert bubble, keep PC/BD of the squashed slot
//   hold              : freeze every stage register
//   d_valid..d_payload: upstream stage fields
//   q_valid..q_payload: this stage's fields (q_pc8 = q_pc + 8)
//   bubble_cnt        : saturating count of clr-inserted bubbles
module pipe_stage_reg
    import cpu_pkg::*;
#(
    parameter int          PAYLOAD_W  = 128,
    parameter int          TNEW_W     = 2,
    parameter bit          TNEW_DEC   = 1'b1,
    parameter logic [31:0] HANDLER_PC = HANDLER_PC_DEFAULT,
    parameter int          CNT_W      = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req,
    input  logic                 clr,
    input  logic                 hold,
    input  logic                 d_valid,
    input  logic [31:0]          d_pc,
    input  logic                 d_bd,
    input  logic [4:0]           d_exc,
    input  logic [TNEW_W-1:0]    d_tnew,
    input  logic [PAYLOAD_W-1:0] d_payload,
    output logic                 q_valid,
    output logic [31:0]          q_pc,
    output logic [31:0]          q_pc8,
    output logic                 q_bd,
    output logic [4:0]           q_exc,
    output logic [TNEW_W-1:0]    q_tnew,
    output logic [PAYLOAD_W-1:0] q_payload,
    output logic [CNT_W-1:0]     bubble_cnt
);

    // T_new counts the stages until the result is ready; moving one stage
    // further down the pipe brings it one cycle closer, floored at zero.
    logic [TNEW_W-1:0] tnew_next;

    always_comb begin
        tnew_next = d_tnew;
        if (TNEW_DEC && (d_tnew != '0)) begin
            tnew_next = d_tnew - TNEW_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_valid   <= 1'b0;
            q_pc      <= '0;
            q_pc8     <= '0;
            q_bd      <= 1'b0;
            q_exc     <= EXC_NONE;
            q_tnew    <= '0;
            q_payload <= '0;
        end else if (req) begin
            q_valid   <= 1'b0;
            q_pc      <= HANDLER_PC;
            q_pc8     <= HANDLER_PC + PC8_OFFSET;
            q_bd      <= 1'b0;
            q_exc     <= EXC_NONE;
            q_tnew    <= '0;
            q_payload <= '0;
        end else if (clr) begin
            // The bubble still carries PC/BD so a later interrupt taken on
            // this slot reports the correct EPC and Cause.BD.
            q_valid   <= 1'b0;
            q_pc      <= d_pc;
            q_pc8     <= d_pc + PC8_OFFSET;
            q_bd      <= d_bd;
            q_exc     <= EXC_NONE;
            q_tnew    <= '0;
            q_payload <= '0;
        end else if (!hold) begin
            q_valid   <= d_valid;
            q_pc      <= d_pc;
            q_pc8     <= d_pc + PC8_OFFSET;
            q_bd      <= d_bd;
            q_exc     <= d_exc;
            q_tnew    <= tnew_next;
            q_payload <= d_payload;
        end
    end

    // Only explicit hazard bubbles are counted; a flush takes precedence
    // over clr and therefore does not count.
    sat_counter #(
        .CNT_W (CNT_W)
    ) u_bubble_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (clr && !req),
        .count (bubble_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg. A second instance with a 2-bit
// counter and T_new pass-through shares all inputs with the main one.
module tb_pipe_stage_reg;

    logic         clk = 1'b0;
    logic         reset;
    logic         req, clr, hold;
    logic         d_valid, d_bd;
    logic [31:0]  d_pc;
    logic [4:0]   d_exc;
    logic [1:0]   d_tnew;
    logic [127:0] d_payload;

    logic         q_valid, q_bd;
    logic [31:0]  q_pc, q_pc8;
    logic [4:0]   q_exc;
    logic [1:0]   q_tnew;
    logic [127:0] q_payload;
    logic [15:0]  bubble_cnt;

    logic         q2_valid, q2_bd;
    logic [31:0]  q2_pc, q2_pc8;
    logic [4:0]   q2_exc;
    logic [1:0]   q2_tnew;
    logic [127:0] q2_payload;
    logic [1:0]   bubble_cnt2;

    always #5 clk = ~clk;

    pipe_stage_reg dut (
        .clk(clk), .reset(reset), .req(req), .clr(clr), .hold(hold),
        .d_valid(d_valid), .d_pc(d_pc), .d_bd(d_bd), .d_exc(d_exc),
        .d_tnew(d_tnew), .d_payload(d_payload),
        .q_valid(q_valid), .q_pc(q_pc), .q_pc8(q_pc8), .q_bd(q_bd),
        .q_exc(q_exc), .q_tnew(q_tnew), .q_payload(q_payload),
        .bubble_cnt(bubble_cnt)
    );

    pipe_stage_reg #(.TNEW_DEC(1'b0), .CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .req(req), .clr(clr), .hold(hold),
        .d_valid(d_valid), .d_pc(d_pc), .d_bd(d_bd), .d_exc(d_exc),
        .d_tnew(d_tnew), .d_payload(d_payload),
        .q_valid(q2_valid), .q_pc(q2_pc), .q_pc8(q2_pc8), .q_bd(q2_bd),
        .q_exc(q2_exc), .q_tnew(q2_tnew), .q_payload(q2_payload),
        .bubble_cnt(bubble_cnt2)
    );

    typedef struct packed {
        logic         valid;
        logic [31:0]  pc;
        logic [31:0]  pc8;
        logic         bd;
        logic [4:0]   exc;
        logic [1:0]   tnew;
        logic [1:0]   tnew2;
        logic [127:0] payload;
        logic [15:0]  cnt;
        logic [1:0]   cnt2;
    } exp_t;

    exp_t m;          // expected state after the last edge
    exp_t sb[$];      // expected results awaiting comparison
    exp_t e, o;
    int   checks = 0;
    int   errors = 0;

    localparam logic [127:0] PAT = {64{2'b10}};

    // Second instance must agree with the first on every shared field.
    function automatic exp_t sample();
        exp_t s;
        s.valid   = (q_valid   === q2_valid)   ? q_valid   : 1'bx;
        s.pc      = (q_pc      === q2_pc)      ? q_pc      : 'x;
        s.pc8     = (q_pc8     === q2_pc8)     ? q_pc8     : 'x;
        s.bd      = (q_bd      === q2_bd)      ? q_bd      : 1'bx;
        s.exc     = (q_exc     === q2_exc)     ? q_exc     : 'x;
        s.tnew    = q_tnew;
        s.tnew2   = q2_tnew;
        s.payload = (q_payload === q2_payload) ? q_payload : 'x;
        s.cnt     = bubble_cnt;
        s.cnt2    = bubble_cnt2;
        return s;
    endfunction

    // Drive one cycle of stimulus, push the expected outcome, and step to
    // just after the next rising edge.
    task automatic cycle(input logic r, input logic c, input logic h,
                         input logic v, input logic [31:0] pc, input logic bd,
                         input logic [4:0] exc, input logic [1:0] tn,
                         input logic [127:0] pl);
        exp_t n;
        req = r; clr = c; hold = h;
        d_valid = v; d_pc = pc; d_bd = bd; d_exc = exc; d_tnew = tn; d_payload = pl;
        n = m;
        if (r) begin
            n.valid = 1'b0; n.pc = 32'h0000_4180; n.pc8 = 32'h0000_4188;
            n.bd = 1'b0; n.exc = 5'd0; n.tnew = 2'd0; n.tnew2 = 2'd0; n.payload = '0;
        end else if (c) begin
            n.valid = 1'b0; n.pc = pc; n.pc8 = pc + 32'd8; n.bd = bd;
            n.exc = 5'd0; n.tnew = 2'd0; n.tnew2 = 2'd0; n.payload = '0;
            if (n.cnt != 16'hFFFF) n.cnt = n.cnt + 16'd1;
            if (n.cnt2 != 2'b11)   n.cnt2 = n.cnt2 + 2'd1;
        end else if (!h) begin
            n.valid = v; n.pc = pc; n.pc8 = pc + 32'd8; n.bd = bd; n.exc = exc;
            n.tnew = (tn == 2'd0) ? 2'd0 : tn - 2'd1;
            n.tnew2 = tn; n.payload = pl;
        end
        m = n;
        sb.push_back(n);
        @(posedge clk);
        #1;
    endtask

    // Pulse reset between edges; state is zero at once and the model follows.
    task automatic mid_reset(input string name);
        #2 reset = 1'b1;
        #1;
        o = sample();
        checks++;
        if (o !== '0) begin
            errors++;
            $display("FAIL %s: got %h want all zero", name, o);
        end
        reset = 1'b0;
        m = '0;
    endtask

    task automatic test_reset();
        o = sample();
        checks++;
        if (o !== '0) begin
            errors++;
            $display("FAIL reset_init: got %h want all zero", o);
        end
        cycle(0, 0, 0, 1, 32'h0000_3000, 0, 5'd0, 2'd1, PAT);
        e = sb.pop_front(); o = sample(); checks++;
        if (o !== e) begin errors++; $display("FAIL reset_preload: got %h want %h", o, e); end
        mid_reset("reset_async");
    endtask

    task automatic test_load();
        cycle(0, 0, 0, 1, 32'h0000_3008, 0, 5'd4, 2'd2, PAT);
        e = sb.pop_front(); o = sample(); checks++;
        if (o !== e) begin errors++; $display("FAIL load_a: got %h want %h", o, e); end
        checks++;
        if (q_pc8 !== 32'h0000_3010 || q_tnew !== 2'd1 || q_exc !== 5'd4 ||
            q_payload !== PAT || q2_tnew !== 2'd2 || q_valid !== 1'b1) begin
            errors++;
            $display("FAIL load_a_fields: got pc8=%h tnew=%0d tnew2=%0d exc=%0d valid=%b want 3010/1/2/4/1",
                     q_pc8, q_tnew, q2_tnew, q_exc, q_valid);
        end
        cycle(0, 0, 0, 1, 32'h0000_300C, 1, 5'd0, 2'd0, ~PAT);
        e = sb.pop_front(); o = sample(); checks++;
        if (o !== e) begin errors++; $display("FAIL load_tnew0: got %h want %h", o, e); end
        checks++;
        if (q_tnew !== 2'd0) begin
            errors++; $display("FAIL load_tnew0_sat: got %0d want 0", q_tnew);
        end
        cycle(0, 0, 0, 1, 32'hFFFF_FFFC, 0, 5'd0, 2'd3, PAT);
        e = sb.pop_front(); o = sample(); checks++;
        if (o !== e) begin errors++; $display("FAIL load_wrap: got %h want %h", o, e); end
        checks++;
        if (q_pc8 !== 32'h0000_0004 || q_tnew !== 2'd2) begin
            errors++; $display("FAIL load_wrap_pc8: got pc8=%h tnew=%0d want 00000004/2", q_pc8, q_tnew);
        end
    endtask

    task automatic test_bubble();
        cycle(0, 1, 0, 1, 32'h0000_3010, 1, 5'd10, 2'd3, PAT);
        e = sb.pop_front(); o = sample(); checks++;
        if (o !== e) begin errors++; $display("FAIL bubble_1: got %h want %h", o, e); end
        checks++;
        if (q_valid !== 1'b0 || q_pc !== 32'h0000_3010 || q_bd !== 1'b1 || q_exc !== 5'd0 ||
            q_tnew !== 2'd0 || q_payload !== '0 || bubble_cnt !== 16'd1) begin
            errors++;
            $display("FAIL bubble_1_fields: got valid=%b pc=%h bd=%b exc=%0d tnew=%0d cnt=%0d want 0/3010/1/0/0/1",
                     q_valid, q_pc, q_bd, q_exc, q_tnew, bubble_cnt);
        end
        for (int i = 0; i < 2; i++) begin
            cycle(0, 1, 0, 1, 32'h0000_3014 + 32'(4 * i), 0, 5'd12, 2'd1, PAT);
            e = sb.pop_front(); o = sample(); checks++;
            if (o !== e) begin errors++; $display("FAIL bubble_run: got %h want %h", o, e); end
        end
        checks++;
        if (bubble_cnt !== 16'd3) begin
            errors++; $display("FAIL bubble_cnt3: got %0d want 3", bubble_cnt);
        end
    endtask

    task automatic test_flush();
        cycle(1, 1, 0, 1, 32'h0000_3020, 1, 5'd8, 2'd2, PAT);
        e = sb.pop_front(); o = sample(); checks++;
        if (o !== e) begin errors++; $display("FAIL flush: got %h want %h", o, e); end
        checks++;
        if (q_pc !== 32'h0000_4180 || q_pc8 !== 32'h0000_4188 || q_bd !== 1'b0 ||
            q_valid !== 1'b0 || bubble_cnt !== 16'd3) begin
            errors++;
            $display("FAIL flush_fields: got pc=%h pc8=%h bd=%b valid=%b cnt=%0d want 4180/4188/0/0/3",
                     q_pc, q_pc8, q_bd, q_valid, bubble_cnt);
        end
    endtask

    task automatic test_hold();
        cycle(0, 0, 0, 1, 32'h0000_3040, 0, 5'd0, 2'd2, PAT);
        e = sb.pop_front(); o = sample(); checks++;
        if (o !== e) begin errors++; $display("FAIL hold_load: got %h want %h", o, e); end
        for (int i = 0; i < 4; i++) begin
            cycle(0, 0, 1, 1'($urandom), $urandom, 1'($urandom), 5'($urandom), 2'($urandom),
                  {$urandom, $urandom, $urandom, $urandom});
            e = sb.pop_front(); o = sample(); checks++;
            if (o !== e || q_pc !== 32'h0000_3040 || q_tnew !== 2'd1) begin
                errors++; $display("FAIL hold_keep: got %h want %h", o, e);
            end
        end
        cycle(0, 1, 1, 1, 32'h0000_3050, 1, 5'd4, 2'd3, PAT);
        e = sb.pop_front(); o = sample(); checks++;
        if (o !== e || q_valid !== 1'b0 || q_pc !== 32'h0000_3050 || bubble_cnt !== 16'd4) begin
            errors++; $display("FAIL hold_clr: got %h want %h", o, e);
        end
    endtask

    task automatic test_saturation();
        logic [1:0] want2 [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        mid_reset("sat_reset");
        for (int i = 0; i < 5; i++) begin
            cycle(0, 1, 0, 1, 32'h0000_3100 + 32'(4 * i), 0, 5'd0, 2'd1, PAT);
            e = sb.pop_front(); o = sample(); checks++;
            if (o !== e || bubble_cnt2 !== want2[i] || bubble_cnt !== 16'(i + 1)) begin
                errors++;
                $display("FAIL sat_step%0d: got cnt=%0d cnt2=%0d want %0d/%0d",
                         i, bubble_cnt, bubble_cnt2, i + 1, want2[i]);
            end
        end
        cycle(0, 1, 0, 1, 32'h0000_3200, 0, 5'd0, 2'd1, PAT);
        e = sb.pop_front(); o = sample(); checks++;
        if (o !== e) begin errors++; $display("FAIL sat_more: got %h want %h", o, e); end
        mid_reset("sat_mid_reset");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 40; i++) begin
            cycle(1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 3) == 0),
                  1'($urandom_range(0, 3) == 0), 1'($urandom), $urandom, 1'($urandom),
                  5'($urandom), 2'($urandom), {$urandom, $urandom, $urandom, $urandom});
            e = sb.pop_front(); o = sample(); checks++;
            if (o !== e) begin errors++; $display("FAIL b2b_%0d: got %h want %h", i, o, e); end
        end
    endtask

    initial begin
        reset = 1'b1;
        req = 0; clr = 0; hold = 0;
        d_valid = 0; d_pc = '0; d_bd = 0; d_exc = '0; d_tnew = '0; d_payload = '0;
        m = '0;
        #12 reset = 1'b0;
        test_reset();
        test_load();
        test_bubble();
        test_flush();
        test_hold();
        test_saturation();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
